pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Holds the architectural PC and fetches one instruction per step from instruction memory over a req/ack handshake. It presents the instruction to the datapath and waits for the datapath to consume it. On consume it loads the next PC computed by the next-PC logic (pc_next), then refetches. It is the consumer end of the next-PC interface: it takes pc_next and returns pc/pc_plus_4 to the next-PC logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
pc_next  in  32  next PC from next-PC logic; sampled only on instr_take.
instr_take  in  1  datapath has consumed the current instruction; load pc_next.
halt  in  1  halt request (syscall); qualified by instr_take.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address, equals pc.
imem_ack  in  1  memory returns data this cycle.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
pc  out  32  current PC (registered).
pc_plus_4  out  32  pc + 4, combinational.
instr  out  32  registered instruction word.
instr_valid  out  1  instr holds the instruction at pc.
halted  out  1  unit stopped.
misalign  out  1  sticky; pc_next had nonzero bits [1:0].

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n=0.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, halted=0, misalign=0, state=S_IDLE, imem_req=0.
- FSM states: S_IDLE, S_FETCH, S_ISSUE, S_HALT.
- S_IDLE: no outputs active. The state moves to S_FETCH unconditionally on the first clk edge after reset release.
- S_FETCH: imem_req=1 and imem_addr=pc. Both are decoded from the state, and both stay stable until ack.
  - imem_ack=1 at an edge: instr<=imem_rdata, instr_valid<=1, next state S_ISSUE.
  - Ack may arrive in the first S_FETCH cycle (zero wait). Fetch latency is therefore at least 1 cycle from entering S_FETCH to instr_valid.
- S_ISSUE: imem_req=0; instr and instr_valid are held.
  - instr_take=1 at an edge: pc<={pc_next[31:2],2'b00}, instr_valid<=0.
  - Next state is S_HALT if halt=1, otherwise S_FETCH.
  - If pc_next[1:0]!=0 on take, misalign<=1. It stays set until reset.
- S_HALT: halted=1, imem_req=0, instr_valid=0. The pc holds its last loaded value. Exit is by reset only.
- Ignored inputs:
  - imem_ack outside S_FETCH.
  - instr_take and halt outside S_ISSUE.
  - halt without instr_take.
- pc_plus_4: wraps modulo 2^32, so 32'hFFFF_FFFC gives 0.
- Reset asserted mid-fetch: imem_req drops asynchronously. No instruction is latched.
- Steady-state throughput: at most one instruction per 2 cycles (FETCH, ISSUE).

Optional Feature:
- Macro: FETCH_STATS_EN.
- With the macro defined:
  - Adds output fetch_count (32 bits), reset 0.
  - It increments on each accepted imem_ack in S_FETCH and wraps modulo 2^32.
- Without the macro: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (S_IDLE, S_FETCH, S_ISSUE, S_HALT);
  - the default RESET_PC constant;
  - the instruction word width constant (32).
- Sub-module: pc_reg. It is a 32-bit register with load enable, async active-low reset to RESET_PC, and alignment masking. The FSM stays in pc_fetch_unit.

Test Plan:
1. Reset values. Hold rst_n=0 with RESET_PC=0 -> pc=0, instr_valid=0, imem_req=0, halted=0. After release, imem_req=1 with imem_addr=0 on cycle 2.
2. Zero-wait ack. imem_ack=1 with imem_rdata=32'h2008_0005 in the first S_FETCH cycle -> instr=32'h2008_0005 and instr_valid=1 next cycle; imem_req=0.
3. Three wait states. Ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles. instr_valid rises only after ack.
4. Branch load. instr_take=1 with pc_next=32'h0000_0040 -> pc=0x40, pc_plus_4=0x44, imem_addr=0x40 next cycle.
5. Misalign and wrap:
   - pc_next=32'h0000_0042 on take -> pc=0x40, misalign=1, sticky across later takes.
   - pc loaded with 32'hFFFF_FFFC -> pc_plus_4=0.
6. Halt and mid-fetch reset:
   - halt=1 with instr_take=1 -> halted=1 and imem_req stays 0 for 10+ cycles even with imem_ack pulses.
   - rst_n pulsed low during S_FETCH -> immediate return to reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the PC fetch unit.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] FETCH_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_HALT
   } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register. It has a load enable, and every loaded value is
// word-aligned by clearing bits [1:0].
module pc_reg
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld,
   input  logic [INSTR_W-1:0] d,
   output logic [INSTR_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= RESET_PC;
      else if (ld) q <= d & ~32'h3;
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and single-outstanding instruction fetcher (FETCH -> ISSUE loop).
// Define FETCH_STATS_EN to add the fetch_count output (count of accepted fetches).
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INSTR_W-1:0] pc_next,
   input  logic               instr_take,
   input  logic               halt,
   output logic               imem_req,
   output logic [INSTR_W-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] pc,
   output logic [INSTR_W-1:0] pc_plus_4,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               halted,
`ifdef FETCH_STATS_EN
   output logic [INSTR_W-1:0] fetch_count,
`endif
   output logic               misalign
);

   fetch_state_e state_q, state_d;
   logic         ack_fire;
   logic         take_fire;

   // Inputs are only honoured in the state that expects them.
   assign ack_fire  = (state_q == S_FETCH) && imem_ack;
   assign take_fire = (state_q == S_ISSUE) && instr_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      halted   = 1'b0;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (instr_take) state_d = halt ? S_HALT : S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         default: state_d = S_IDLE;
      endcase
   end

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (take_fire),
      .d     (pc_next),
      .q     (pc)
   );

   assign imem_addr = pc;
   assign pc_plus_4 = pc + 32'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr       <= '0;
         instr_valid <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         if (ack_fire) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
         end else if (take_fire) begin
            instr_valid <= 1'b0;
         end
         if (take_fire && (pc_next[1:0] != 2'b00)) misalign <= 1'b1;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        fetch_count <= '0;
      else if (ack_fire) fetch_count <= fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_next;
   logic        instr_take;
   logic        halt;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus_4;
   logic [31:0] instr;
   logic        instr_valid;
   logic        halted;
   logic        misalign;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_next     (pc_next),
      .instr_take  (instr_take),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .pc_plus_4   (pc_plus_4),
      .instr       (instr),
      .instr_valid (instr_valid),
      .halted      (halted),
`ifdef FETCH_STATS_EN
      .fetch_count (fetch_count),
`endif
      .misalign    (misalign)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Sample 1 time unit after the rising edge; inputs changed here hold for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; pc_next = '0; instr_take = 1'b0; halt = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0;
      #12;
      // reset values
      chk("rst_pc", pc, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("idle_req", {31'b0, imem_req}, 32'd0);
      step();
      chk("fetch0_req", {31'b0, imem_req}, 32'd1);
      chk("fetch0_addr", imem_addr, 32'h0);

      // zero-wait ack
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
      step();
      imem_ack = 1'b0;
      chk("zw_instr", instr, 32'h2008_0005);
      chk("zw_valid", {31'b0, instr_valid}, 32'd1);
      chk("zw_req", {31'b0, imem_req}, 32'd0);

      // three wait states
      instr_take = 1'b1; pc_next = 32'h0000_0010;
      step();
      instr_take = 1'b0;
      chk("ws_pc", pc, 32'h10);
      chk("ws_valid0", {31'b0, instr_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("ws_req", {31'b0, imem_req}, 32'd1);
         chk("ws_addr", imem_addr, 32'h10);
         chk("ws_valid", {31'b0, instr_valid}, 32'd0);
         if (i < 3) step();
      end
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
      step();
      imem_ack = 1'b0;
      chk("ws_instr", instr, 32'hAAAA_5555);
      chk("ws_valid1", {31'b0, instr_valid}, 32'd1);

      // branch load
      instr_take = 1'b1; pc_next = 32'h0000_0040;
      step();
      instr_take = 1'b0;
      chk("br_pc", pc, 32'h40);
      chk("br_pc4", pc_plus_4, 32'h44);
      chk("br_addr", imem_addr, 32'h40);
      chk("br_misalign", {31'b0, misalign}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_1234;
      step();
      imem_ack = 1'b0;

      // misaligned target
      instr_take = 1'b1; pc_next = 32'h0000_0042;
      step();
      instr_take = 1'b0;
      chk("mis_pc", pc, 32'h40);
      chk("mis_flag", {31'b0, misalign}, 32'd1);

      // take is ignored while fetching
      instr_take = 1'b1; pc_next = 32'h0000_0100;
      step();
      instr_take = 1'b0;
      chk("ign_take_pc", pc, 32'h40);
      chk("ign_take_req", {31'b0, imem_req}, 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      step();
      imem_ack = 1'b0;
      chk("mis_instr", instr, 32'h1111_2222);

      // ack is ignored while issuing
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      chk("ign_ack_instr", instr, 32'h1111_2222);
      chk("ign_ack_valid", {31'b0, instr_valid}, 32'd1);

      // halt without take does nothing
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("ign_halt", {31'b0, halted}, 32'd0);
      chk("ign_halt_valid", {31'b0, instr_valid}, 32'd1);

      // wrap of pc_plus_4, misalign stays sticky across an aligned take
      instr_take = 1'b1; pc_next = 32'hFFFF_FFFC;
      step();
      instr_take = 1'b0;
      chk("wrap_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", pc_plus_4, 32'h0);
      chk("mis_sticky", {31'b0, misalign}, 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h0000_000C;
      step();
      imem_ack = 1'b0;

      // halt with take
      instr_take = 1'b1; halt = 1'b1; pc_next = 32'h0000_0080;
      step();
      instr_take = 1'b0; halt = 1'b0;
      chk("halt_flag", {31'b0, halted}, 32'd1);
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h80);
      for (int i = 0; i < 10; i++) begin
         imem_ack = i[0]; imem_rdata = 32'hBAD0_0000 | i;
         instr_take = 1'b1; pc_next = 32'h0000_0200;
         step();
         chk("halt_hold_req", {31'b0, imem_req}, 32'd0);
         chk("halt_hold_flag", {31'b0, halted}, 32'd1);
         chk("halt_hold_pc", pc, 32'h80);
         chk("halt_hold_valid", {31'b0, instr_valid}, 32'd0);
      end
      imem_ack = 1'b0; instr_take = 1'b0;
`ifdef FETCH_STATS_EN
      chk("fetch_count", fetch_count, 32'd5);
`endif

      // reset leaves the halt state immediately
      rst_n = 1'b0;
      #1;
      chk("hrst_halted", {31'b0, halted}, 32'd0);
      chk("hrst_pc", pc, 32'h0);
      chk("hrst_misalign", {31'b0, misalign}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("mf_req", {31'b0, imem_req}, 32'd1);
      chk("mf_addr", imem_addr, 32'h0);

      // reset asserted mid-fetch with ack pending
      imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
      #3;
      rst_n = 1'b0;
      #1;
      chk("mf_req_drop", {31'b0, imem_req}, 32'd0);
      chk("mf_pc", pc, 32'h0);
      step();
      chk("mf_instr", instr, 32'h0);
      chk("mf_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_STATS_EN
      chk("mf_count", fetch_count, 32'd0);
`endif
      imem_ack = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("mf_idle_req", {31'b0, imem_req}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
